// File: rtl/hazard_unit_mc_pkg.sv
// hazard_pkg: definitions shared by the hazard unit, its MDU occupancy FSM
// and the interface between them.
//   FWD_*              operand-select encodings driven on o_ForwardA/B_E
//   RESULTSRC_LOAD_BIT bit of ResultSrc_E that marks a load
//   mdu_state_t        RUN (normal issue) / MDU (multi-cycle op holding E)
package hazard_pkg;
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_W   = 2'b01;
   localparam logic [1:0] FWD_M   = 2'b10;

   localparam int RESULTSRC_LOAD_BIT = 0;

   typedef enum logic {
      RUN = 1'b0,
      MDU = 1'b1
   } mdu_state_t;
endpackage

// File: rtl/hazard_unit_mc_if.sv
// hazard_unit_mc_if: control bundle between the hazard unit (master) and the
// MDU occupancy FSM (slave).
//   mdu_start  multi-cycle op wants to begin (already masked by branch)
//   freeze     data memory not ready; FSM holds all state
//   mdu_stall  FSM needs F/D/E held and a bubble into M
//   mdu_busy   FSM is in the MDU state
//   mdu_done   final E cycle of the multi-cycle op
interface hazard_unit_mc_if;
   logic mdu_start;
   logic freeze;
   logic mdu_stall;
   logic mdu_busy;
   logic mdu_done;

   modport master (output mdu_start, output freeze,
                   input  mdu_stall, input  mdu_busy, input mdu_done);
   modport slave  (input  mdu_start, input  freeze,
                   output mdu_stall, output mdu_busy, output mdu_done);
endinterface

// File: rtl/hazard_unit_mc_mdu_occupancy_fsm.sv
// mdu_occupancy_fsm: tracks how long a multi-cycle execute op has held E.
//   i_CLK, i_RST  clock, synchronous active-high reset
//   bus (slave)   start/freeze in; stall/busy/done out
// The first occupancy cycle is spent in RUN (the op just arrived), so the
// counter is loaded with MDU_LAT-2 and the op leaves when it reaches zero.
module mdu_occupancy_fsm
   import hazard_pkg::*;
#(
   parameter int MDU_LAT = 4
) (
   input  logic             i_CLK,
   input  logic             i_RST,
   hazard_unit_mc_if.slave  bus
);
   localparam int          CW       = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
   localparam bit          MULTI    = (MDU_LAT >= 2);
   localparam logic [CW-1:0] CNT_INIT = CW'((MDU_LAT >= 2) ? (MDU_LAT - 2) : 0);

   mdu_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bus.mdu_stall = 1'b0;
      bus.mdu_done  = 1'b0;
      unique case (state_q)
         RUN: begin
            if (bus.mdu_start) begin
               if (MULTI) begin
                  bus.mdu_stall = 1'b1;
                  if (!bus.freeze) begin
                     state_d = MDU;
                     cnt_d   = CNT_INIT;
                  end
               end else begin
                  bus.mdu_done = ~bus.freeze;
               end
            end
         end
         MDU: begin
            // a freeze pauses the count, stretching occupancy one cycle each
            if (cnt_q != '0) begin
               bus.mdu_stall = 1'b1;
               if (!bus.freeze) cnt_d = cnt_q - CW'(1);
            end else begin
               bus.mdu_done = ~bus.freeze;
               if (!bus.freeze) state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.mdu_busy = (state_q == MDU);
endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: stage enables/flushes and forwarding for the 5-stage pipe.
//   i_CLK, i_RST            clock, synchronous active-high reset
//   i_RS*/i_Rd*/RegWrite*   per-stage register fields for hazards/forwarding
//   i_ResultSrc_E, i_PCSrc_E, i_MduStart_E  E-stage load / branch / MDU op
//   i_MemReq_M, i_MemReady_M  data-memory wait -> whole-pipe freeze
//   i_CntClr                clears the performance counters
//   o_Stall_*/o_Flush_*     stage register hold / bubble insert
//   o_ForwardA/B_E          operand source select
//   o_MduBusy, o_MduDone    MDU occupancy status
//   o_StallCycles, o_FlushCount  saturating performance counters
// Priority: freeze > MDU stall > branch > load-use.
module hazard_unit_mc
   import hazard_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int MDU_LAT    = 4,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic [ADDR_WIDTH-1:0] i_RS1_D,
   input  logic [ADDR_WIDTH-1:0] i_RS2_D,
   input  logic [ADDR_WIDTH-1:0] i_RS1_E,
   input  logic [ADDR_WIDTH-1:0] i_RS2_E,
   input  logic [ADDR_WIDTH-1:0] i_Rd_E,
   input  logic [1:0]            i_ResultSrc_E,
   input  logic                  i_PCSrc_E,
   input  logic                  i_MduStart_E,
   input  logic [ADDR_WIDTH-1:0] i_Rd_M,
   input  logic                  i_RegWrite_M,
   input  logic                  i_MemReq_M,
   input  logic                  i_MemReady_M,
   input  logic [ADDR_WIDTH-1:0] i_Rd_W,
   input  logic                  i_RegWrite_W,
   input  logic                  i_CntClr,
   output logic                  o_Stall_F,
   output logic                  o_Stall_D,
   output logic                  o_Stall_E,
   output logic                  o_Stall_M,
   output logic                  o_Flush_D,
   output logic                  o_Flush_E,
   output logic                  o_Flush_M,
   output logic                  o_Flush_W,
   output logic [1:0]            o_ForwardA_E,
   output logic [1:0]            o_ForwardB_E,
   output logic                  o_MduBusy,
   output logic                  o_MduDone,
   output logic [CNT_WIDTH-1:0]  o_StallCycles,
   output logic [CNT_WIDTH-1:0]  o_FlushCount
);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   function automatic logic [1:0] fwd_sel(
      input logic [ADDR_WIDTH-1:0] rs,
      input logic [ADDR_WIDTH-1:0] rd_m, input logic we_m,
      input logic [ADDR_WIDTH-1:0] rd_w, input logic we_w);
      if (rs != '0 && we_m && rs == rd_m)      return FWD_M;
      else if (rs != '0 && we_w && rs == rd_w) return FWD_W;
      else                                     return FWD_REG;
   endfunction

   logic freeze, load_use, mdu_stall;
   logic unused_resultsrc;

   assign unused_resultsrc = i_ResultSrc_E[1];
   assign freeze   = i_MemReq_M & ~i_MemReady_M;
   assign load_use = i_ResultSrc_E[RESULTSRC_LOAD_BIT] & (i_Rd_E != '0) &
                     ((i_Rd_E == i_RS1_D) | (i_Rd_E == i_RS2_D));

   assign o_ForwardA_E = fwd_sel(i_RS1_E, i_Rd_M, i_RegWrite_M, i_Rd_W, i_RegWrite_W);
   assign o_ForwardB_E = fwd_sel(i_RS2_E, i_Rd_M, i_RegWrite_M, i_Rd_W, i_RegWrite_W);

   hazard_unit_mc_if mdu_bus ();

   // a taken branch squashes the op in E, so it must not start the MDU
   assign mdu_bus.mdu_start = i_MduStart_E & ~i_PCSrc_E;
   assign mdu_bus.freeze    = freeze;
   assign mdu_stall         = mdu_bus.mdu_stall;
   assign o_MduBusy         = mdu_bus.mdu_busy;
   assign o_MduDone         = mdu_bus.mdu_done;

   mdu_occupancy_fsm #(.MDU_LAT(MDU_LAT)) u_mdu (
      .i_CLK (i_CLK),
      .i_RST (i_RST),
      .bus   (mdu_bus.slave)
   );

   always_comb begin
      o_Stall_F = 1'b0;
      o_Stall_D = 1'b0;
      o_Stall_E = 1'b0;
      o_Stall_M = 1'b0;
      o_Flush_D = 1'b0;
      o_Flush_E = 1'b0;
      o_Flush_M = 1'b0;
      o_Flush_W = 1'b0;
      if (freeze) begin
         // hold everything; the instruction leaving M is not yet complete
         o_Stall_F = 1'b1;
         o_Stall_D = 1'b1;
         o_Stall_E = 1'b1;
         o_Stall_M = 1'b1;
         o_Flush_W = 1'b1;
      end else if (mdu_stall) begin
         o_Stall_F = 1'b1;
         o_Stall_D = 1'b1;
         o_Stall_E = 1'b1;
         o_Flush_M = 1'b1;
      end else if (i_PCSrc_E) begin
         o_Flush_D = 1'b1;
         o_Flush_E = 1'b1;
      end else if (load_use) begin
         o_Stall_F = 1'b1;
         o_Stall_D = 1'b1;
         o_Flush_E = 1'b1;
      end
   end

   logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_WIDTH-1:0] flush_count_q,  flush_count_d;

   // o_Flush_D is raised only by an honoured branch, so it marks the event
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (i_CntClr) begin
         stall_cycles_d = '0;
         flush_count_d  = '0;
      end else begin
         if (o_Stall_F && stall_cycles_q != CNT_MAX)
            stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
         if (o_Flush_D && flush_count_q != CNT_MAX)
            flush_count_d = flush_count_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign o_StallCycles = stall_cycles_q;
   assign o_FlushCount  = flush_count_q;
endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;
   localparam int LAT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, pcsrc, start, rw_m, rw_w, memreq, memrdy, clr;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic [1:0] rsrc;

   logic        sf, sd, se, sm, fd, fe, fm, fw, busy, done;
   logic [1:0]  fa, fb;
   logic [31:0] stall_cnt, flush_cnt;

   logic        d4_sf, d4_sd, d4_se, d4_sm, d4_fd, d4_fe, d4_fm, d4_fw, d4_busy, d4_done;
   logic [1:0]  d4_fa, d4_fb;
   logic [3:0]  d4_stall_cnt, d4_flush_cnt;

   hazard_unit_mc #(.ADDR_WIDTH(5), .MDU_LAT(LAT), .CNT_WIDTH(32)) u_dut (
      .i_CLK(clk), .i_RST(rst), .i_RS1_D(rs1_d), .i_RS2_D(rs2_d),
      .i_RS1_E(rs1_e), .i_RS2_E(rs2_e), .i_Rd_E(rd_e), .i_ResultSrc_E(rsrc),
      .i_PCSrc_E(pcsrc), .i_MduStart_E(start), .i_Rd_M(rd_m), .i_RegWrite_M(rw_m),
      .i_MemReq_M(memreq), .i_MemReady_M(memrdy), .i_Rd_W(rd_w), .i_RegWrite_W(rw_w),
      .i_CntClr(clr), .o_Stall_F(sf), .o_Stall_D(sd), .o_Stall_E(se), .o_Stall_M(sm),
      .o_Flush_D(fd), .o_Flush_E(fe), .o_Flush_M(fm), .o_Flush_W(fw),
      .o_ForwardA_E(fa), .o_ForwardB_E(fb), .o_MduBusy(busy), .o_MduDone(done),
      .o_StallCycles(stall_cnt), .o_FlushCount(flush_cnt));

   hazard_unit_mc #(.ADDR_WIDTH(5), .MDU_LAT(LAT), .CNT_WIDTH(4)) u_dut4 (
      .i_CLK(clk), .i_RST(rst), .i_RS1_D(rs1_d), .i_RS2_D(rs2_d),
      .i_RS1_E(rs1_e), .i_RS2_E(rs2_e), .i_Rd_E(rd_e), .i_ResultSrc_E(rsrc),
      .i_PCSrc_E(pcsrc), .i_MduStart_E(start), .i_Rd_M(rd_m), .i_RegWrite_M(rw_m),
      .i_MemReq_M(memreq), .i_MemReady_M(memrdy), .i_Rd_W(rd_w), .i_RegWrite_W(rw_w),
      .i_CntClr(clr), .o_Stall_F(d4_sf), .o_Stall_D(d4_sd), .o_Stall_E(d4_se),
      .o_Stall_M(d4_sm), .o_Flush_D(d4_fd), .o_Flush_E(d4_fe), .o_Flush_M(d4_fm),
      .o_Flush_W(d4_fw), .o_ForwardA_E(d4_fa), .o_ForwardB_E(d4_fb),
      .o_MduBusy(d4_busy), .o_MduDone(d4_done),
      .o_StallCycles(d4_stall_cnt), .o_FlushCount(d4_flush_cnt));

   // monitor view of the MDU control bundle
   hazard_unit_mc_if bus_mon ();
   assign bus_mon.mdu_start = start & ~pcsrc;
   assign bus_mon.freeze    = memreq & ~memrdy;
   assign bus_mon.mdu_stall = se & ~sm;
   assign bus_mon.mdu_busy  = busy;
   assign bus_mon.mdu_done  = done;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // occ = number of E cycles the current multi-cycle op has already spent
   int          occ = 0;
   int unsigned m_stall = 0, m_flush = 0, m_stall4 = 0, m_flush4 = 0;

   typedef struct packed {
      logic [1:0] fa, fb;
      logic sf, sd, se, sm, fd, fe, fm, fw, busy, done;
   } exp_t;

   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      if (rs != 0 && rw_m && rs == rd_m) return 2'd2;
      if (rs != 0 && rw_w && rs == rd_w) return 2'd1;
      return 2'd0;
   endfunction

   // E-cycle index of the op in E this cycle (0 = no multi-cycle op)
   function automatic int m_pos();
      if (occ > 0) return occ + 1;
      if (start && !pcsrc) return 1;
      return 0;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      bit   frz, lu;
      int   p;
      e = '0;
      e.fa = m_fwd(rs1_e);
      e.fb = m_fwd(rs2_e);
      frz = memreq && !memrdy;
      lu  = rsrc[0] && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
      p   = m_pos();
      e.busy = (occ > 0);
      e.done = !frz && p == LAT;
      if (frz)                  {e.sf, e.sd, e.se, e.sm, e.fw} = 5'b11111;
      else if (p != 0 && p < LAT) {e.sf, e.sd, e.se, e.fm} = 4'b1111;
      else if (pcsrc)           {e.fd, e.fe} = 2'b11;
      else if (lu)              {e.sf, e.sd, e.fe} = 3'b111;
      return e;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      int   p;
      e = model_out();
      p = m_pos();
      if (rst) begin
         occ <= 0; m_stall <= 0; m_flush <= 0; m_stall4 <= 0; m_flush4 <= 0;
      end else begin
         if (!(memreq && !memrdy)) occ <= (p != 0 && p < LAT) ? p : 0;
         if (clr) begin
            m_stall <= 0; m_flush <= 0; m_stall4 <= 0; m_flush4 <= 0;
         end else begin
            if (e.sf && m_stall  != 32'hFFFF_FFFF) m_stall  <= m_stall + 1;
            if (e.fd && m_flush  != 32'hFFFF_FFFF) m_flush  <= m_flush + 1;
            if (e.sf && m_stall4 != 15)            m_stall4 <= m_stall4 + 1;
            if (e.fd && m_flush4 != 15)            m_flush4 <= m_flush4 + 1;
         end
      end
   end

   always @(negedge clk) begin
      exp_t ce;
      if (chk_on) begin
         ce = model_out();
         chk("fwdA", {30'd0, fa}, {30'd0, ce.fa});
         chk("fwdB", {30'd0, fb}, {30'd0, ce.fb});
         chk("stalls", {28'd0, sf, sd, se, sm}, {28'd0, ce.sf, ce.sd, ce.se, ce.sm});
         chk("flushes", {28'd0, fd, fe, fm, fw}, {28'd0, ce.fd, ce.fe, ce.fm, ce.fw});
         chk("busy", {31'd0, bus_mon.mdu_busy}, {31'd0, ce.busy});
         chk("done", {31'd0, bus_mon.mdu_done}, {31'd0, ce.done});
         chk("stall_cnt", stall_cnt, m_stall);
         chk("flush_cnt", flush_cnt, m_flush);
         chk("stall_cnt4", {28'd0, d4_stall_cnt}, m_stall4);
         chk("flush_cnt4", {28'd0, d4_flush_cnt}, m_flush4);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
      rsrc = 2'b00; pcsrc = 0; start = 0; rw_m = 0; rw_w = 0;
      memreq = 0; memrdy = 0; clr = 0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      cyc(); cyc();
      rst = 1'b0;
      chk_on = 1'b1;
      #1;
      chk("rst_stalls", {28'd0, sf, sd, se, sm}, 32'd0);
      chk("rst_flushes", {28'd0, fd, fe, fm, fw}, 32'd0);
      chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      chk("rst_flush_cnt", flush_cnt, 32'd0);

      // forwarding: M beats W, then W alone, then x0 never forwards
      cyc();
      rs1_e = 5; rs2_e = 5; rd_m = 5; rw_m = 1; rd_w = 5; rw_w = 1;
      #1 chk("fwdA_M", {30'd0, fa}, 32'd2);
      chk("fwdB_M", {30'd0, fb}, 32'd2);
      cyc();
      rw_m = 0;
      #1 chk("fwdA_W", {30'd0, fa}, 32'd1);
      cyc();
      idle(); rw_m = 1;
      #1 chk("fwdA_x0", {30'd0, fa}, 32'd0);

      // load-use, then the same with a taken branch
      cyc();
      idle(); rsrc = 2'b01; rd_e = 7; rs2_d = 7;
      #1 chk("lu_stall", {29'd0, sf, sd, fe}, 32'b111);
      chk("lu_se", {31'd0, se}, 32'd0);
      cyc();
      pcsrc = 1;
      #1 chk("br_lu_sf", {31'd0, sf}, 32'd0);
      chk("br_flush", {30'd0, fd, fe}, 32'b11);
      cyc();
      idle();
      #1 chk("cnt_after_lu_br", {stall_cnt[15:0], flush_cnt[15:0]}, {16'd1, 16'd1});

      // clear, then a plain 4-cycle MDU op
      clr = 1;
      cyc();
      clr = 0;
      #1 chk("clr", stall_cnt, 32'd0);
      start = 1;
      for (int i = 0; i < LAT; i++) begin
         if (i > 0) cyc();
         #1 chk("mdu_se", {31'd0, se}, {31'd0, i < LAT - 1});
         chk("mdu_done", {31'd0, done}, {31'd0, i == LAT - 1});
      end
      cyc();
      start = 0;
      #1 chk("mdu_stall_cnt", stall_cnt, 32'd3);
      chk("mdu_busy_end", {31'd0, busy}, 32'd0);

      // MDU op with a 2-cycle freeze during its second stall cycle
      clr = 1;
      cyc();
      clr = 0; start = 1;
      cyc();
      memreq = 1; memrdy = 0;
      #1 chk("frz_sm_fw", {30'd0, sm, fw}, 32'b11);
      chk("frz_fm", {31'd0, fm}, 32'd0);
      cyc();
      #1 chk("frz2_sm_fw", {30'd0, sm, fw}, 32'b11);
      cyc();
      memreq = 0;
      #1 chk("frz_c4", {30'd0, se, done}, 32'b10);
      cyc();
      #1 chk("frz_c5", {30'd0, se, done}, 32'b10);
      cyc();
      #1 chk("frz_c6", {30'd0, se, done}, 32'b01);
      cyc();
      start = 0;
      #1 chk("frz_stall_cnt", stall_cnt, 32'd5);

      // reset while cnt=1, with start held into the cycle after reset
      start = 1;
      cyc(); cyc();
      rst = 1;
      cyc();
      rst = 0;
      #1 chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_cnt", stall_cnt | flush_cnt, 32'd0);
      chk("restart_se", {31'd0, se}, 32'd1);
      cyc(); cyc(); cyc();
      #1 chk("restart_done", {31'd0, done}, 32'd1);
      cyc();
      start = 0;

      // branch with MDU start: flush wins; branch during freeze not counted
      pcsrc = 1; start = 1;
      #1 chk("br_mdu", {29'd0, fd, fe, se}, 32'b110);
      cyc();
      start = 0; memreq = 1; memrdy = 0;
      #1 chk("br_frz_fd", {31'd0, fd}, 32'd0);
      cyc();
      memrdy = 1;
      #1 chk("br_memrdy_fd", {31'd0, fd}, 32'd1);
      cyc();
      idle();
      #1 chk("flush_cnt_br", flush_cnt, 32'd2);

      // continuous stall saturates the narrow counter
      rsrc = 2'b01; rd_e = 9; rs1_d = 9;
      for (int i = 0; i < 20; i++) cyc();
      #1 chk("sat4", {28'd0, d4_stall_cnt}, 32'd15);
      clr = 1;
      cyc();
      clr = 0;
      #1 chk("clr_vs_stall", stall_cnt, 32'd0);
      chk("clr_vs_stall4", {28'd0, d4_stall_cnt}, 32'd0);
      cyc();
      #1 chk("cnt_resume", stall_cnt, 32'd1);
      cyc();
      idle();
      cyc(); cyc();

      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Second-generation hazard unit for the 5-stage RISC-V pipeline. It keeps operand forwarding, load-use stalling and branch flushing, and adds three things. A parameterised multi-cycle execute (MDU) occupancy FSM. A data-memory wait freeze. Saturating performance counters. It sits beside the datapath and drives all stage-register enables and flushes.

## Interface
Parameters:
- ADDR_WIDTH, 5, register address width
- MDU_LAT, 4, total E-stage cycles a multi-cycle op occupies (≥1; 1 = single-cycle, no stall)
- CNT_WIDTH, 32, width of each performance counter

Ports:
- i_CLK  in  1  clock
- i_RST  in  1  reset: synchronous, active-high
- i_RS1_D, i_RS2_D  in  ADDR_WIDTH  D-stage source registers
- i_RS1_E, i_RS2_E, i_Rd_E  in  ADDR_WIDTH  E-stage sources and destination
- i_ResultSrc_E  in  2  E-stage result select (bit0 = 1 means load)
- i_PCSrc_E  in  1  branch/jump taken in E
- i_MduStart_E  in  1  multi-cycle op present in E
- i_Rd_M, i_RegWrite_M  in  ADDR_WIDTH, 1  M-stage writeback info
- i_MemReq_M, i_MemReady_M  in  1, 1  M-stage memory access and data-memory ready
- i_Rd_W, i_RegWrite_W  in  ADDR_WIDTH, 1  W-stage writeback info
- i_CntClr  in  1  synchronous counter clear
- o_Stall_F, o_Stall_D, o_Stall_E, o_Stall_M  out  1  active-high hold of stage register
- o_Flush_D, o_Flush_E, o_Flush_M, o_Flush_W  out  1  active-high bubble insert
- o_ForwardA_E, o_ForwardB_E  out  2  operand select: 10 = M, 01 = W, 00 = register file
- o_MduBusy  out  1  FSM in MDU state
- o_MduDone  out  1  final E cycle of a multi-cycle op
- o_StallCycles, o_FlushCount  out  CNT_WIDTH  performance counters

## Operation
- **Forwarding (combinational):**
  - M match = rsX_E == Rd_M & RegWrite_M & rsX_E != 0.
  - W match is the same against the W-stage fields.
  - M has priority over W.
  - Forwarding is computed in every state, including freeze.
- **Freeze:** freeze = i_MemReq_M & ~i_MemReady_M.
  - All four stall outputs = 1 and o_Flush_W = 1.
  - All other flushes = 0.
  - FSM, counter and i_MduStart_E are held or ignored.
- **Load-use:** lw = i_ResultSrc_E[0] & i_Rd_E != 0 & (i_Rd_E == i_RS1_D | i_Rd_E == i_RS2_D).
  - Asserts o_Stall_F, o_Stall_D and o_Flush_E.
- **Branch:** i_PCSrc_E asserts o_Flush_D and o_Flush_E, and suppresses lw stall.
  - i_PCSrc_E & i_MduStart_E together: the flush wins and no MDU start.
- **Priority:** freeze > MDU stall > branch > load-use.
- **MDU FSM**, states RUN and MDU, counter width $clog2(MDU_LAT):
  - RUN, i_MduStart_E=1, MDU_LAT≥2: stall F/D/E, flush M, state←MDU, cnt←MDU_LAT-2.
  - MDU, cnt≠0: stall F/D/E, flush M, cnt←cnt-1.
  - MDU, cnt=0: no stall, o_MduDone=1, state←RUN. The op leaves E this cycle.
  - i_MduStart_E is ignored while in MDU.
- **Counters:**
  - o_StallCycles +1 each cycle o_Stall_F=1.
  - o_FlushCount +1 each cycle i_PCSrc_E is honoured (not during freeze).
  - Both saturate at all-ones. i_CntClr zeroes both and overrides the increment.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and current state, with zero latency.
- A multi-cycle op stalls F/D/E for exactly MDU_LAT-1 cycles, giving MDU_LAT cycles of E occupancy. o_MduDone is high on cycle MDU_LAT of that occupancy.
- Freeze in mid-MDU pauses cnt. Total occupancy extends by the number of freeze cycles.
- Reset values:
  - state=RUN, cnt=0, counters=0.
  - o_MduBusy=0, o_MduDone=0.
  - With inputs idle, all stalls and flushes = 0.
- Reset in mid-MDU returns the FSM to RUN the next cycle.
- i_MduStart_E held high in the cycle after reset restarts the op from a full count.

## Structure
- Shared package hazard_pkg holds:
  - FWD_REG/FWD_W/FWD_M encodings (00/01/10).
  - The RESULTSRC load bit index.
  - The mdu_state_t enum (RUN, MDU).
- One sub-module, mdu_occupancy_fsm, contains the FSM, counter and freeze hold. It outputs mdu_stall, o_MduBusy and o_MduDone.
- The top level holds the forwarding, priority mux and counters.

## Test plan
- rs1_E=5, Rd_M=5, RegWrite_M=1, Rd_W=5, RegWrite_W=1 -> ForwardA=10. Then rs1_E=0 with all match fields 0 -> ForwardA=00.
- Load in E, Rd_E=7, RS2_D=7 -> Stall_F=Stall_D=Flush_E=1. Same with i_PCSrc_E=1 -> Stall_F=0, Flush_D=Flush_E=1.
- MDU_LAT=4, start pulse held -> Stall_E high for 3 cycles, o_MduDone on the 4th, o_StallCycles=3.
- MDU_LAT=4, freeze 2 cycles during the second stall cycle -> Stall_M/Flush_W high for 2 cycles, total E occupancy 6, o_MduDone on the 6th.
- i_RST asserted with cnt=1 in MDU -> next cycle o_MduBusy=0 and counters=0. CNT_WIDTH=4 with continuous stall -> o_StallCycles holds at 15.
- i_CntClr coinciding with a stall -> o_StallCycles=0 next cycle.
